// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer:
// opcode/funct values, ALUControl encodings and the sequencer state type.
package mips_pkg;

  // Primary opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instruction bits [5:0]); 6'h00 is accepted as ADD
  // so that older bench encodings such as 32'h00220800 still execute.
  localparam logic [5:0] FN_ADD_LEGACY = 6'h00;
  localparam logic [5:0] FN_ADD        = 6'h20;
  localparam logic [5:0] FN_SUB        = 6'h22;
  localparam logic [5:0] FN_AND        = 6'h24;
  localparam logic [5:0] FN_OR         = 6'h25;
  localparam logic [5:0] FN_SLT        = 6'h2A;

  // ALUControl encodings understood by the datapath ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational instruction decoder: maps opcode/funct to the ALU controls
// and the instruction class the sequencer needs to pick its path.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       alu_src,
  output logic       reg_dst,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       illegal
);

  // Decode table; anything not listed is illegal and leaves controls at defaults.
  always_comb begin
    alu_ctrl  = ALU_ADD;
    alu_src   = 1'b0;
    reg_dst   = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reg_dst = 1'b1;
        case (funct)
          FN_ADD, FN_ADD_LEGACY: alu_ctrl = ALU_ADD;
          FN_SUB:                alu_ctrl = ALU_SUB;
          FN_AND:                alu_ctrl = ALU_AND;
          FN_OR:                 alu_ctrl = ALU_OR;
          FN_SLT:                alu_ctrl = ALU_SLT;
          default: begin
            reg_dst = 1'b0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        alu_src = 1'b1;
        is_load = 1'b1;
      end
      OP_SW: begin
        alu_src  = 1'b1;
        is_store = 1'b1;
      end
      OP_ADDI: begin
        alu_src = 1'b1;
      end
      OP_BEQ: begin
        alu_ctrl  = ALU_SUB;
        is_branch = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mips_control_fsm.sv
// Multi-cycle control sequencer upstream of the MIPS datapath.
// Accepts one instruction per handshake, walks it through
// IDLE -> DECODE -> EXEC -> (MEM) -> (WB) -> IDLE, drives the datapath
// controls, owns the data-memory handshake and resolves beq.
//
// Build option: define MIPS_MEM_TIMEOUT_EN to add a MEM-state watchdog that
// aborts a memory access after MEM_TIMEOUT_CYCLES cycles without mem_ack.
//
// Handshake: an instruction is transferred on a rising clk edge where
// instr_valid and instr_ready are both 1; instr_ready is 1 only in IDLE
// (and 0 while rst is asserted). The memory access is held (mem_req=1 with
// stable address/data) until the cycle mem_ack=1; mem_ack is ignored when
// mem_req is 0.
module mips_control_fsm
  import mips_pkg::*;
#(
  parameter int DATA_W             = 32,
  parameter int MEM_TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] instr_in,
  output logic [DATA_W-1:0] instruction,
  output logic              ALUScr,
  output logic              RegWrite,
  output logic              RegDst,
  output logic [3:0]        ALUControl,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic              Zero,
  input  logic [DATA_W-1:0] rt_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              branch_taken,
  output logic              illegal,
  output logic [2:0]        state_dbg
);

  state_t            state, state_nx;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] rdata_q;

  logic [3:0] dec_alu_ctrl;
  logic       dec_alu_src;
  logic       dec_reg_dst;
  logic       dec_is_load;
  logic       dec_is_store;
  logic       dec_is_branch;
  logic       dec_illegal;
  logic       to_expire;

  // The decoder always looks at the latched word, so its outputs stay
  // stable from DECODE until the sequencer is back in IDLE.
  mips_alu_decoder u_dec (
    .opcode    (instruction[31:26]),
    .funct     (instruction[5:0]),
    .alu_ctrl  (dec_alu_ctrl),
    .alu_src   (dec_alu_src),
    .reg_dst   (dec_reg_dst),
    .is_load   (dec_is_load),
    .is_store  (dec_is_store),
    .is_branch (dec_is_branch),
    .illegal   (dec_illegal)
  );

`ifdef MIPS_MEM_TIMEOUT_EN
  localparam int TO_W = $clog2(MEM_TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Watchdog: counts MEM cycles without mem_ack, cleared whenever not in MEM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state != S_MEM) begin
      to_cnt <= '0;
    end else if (!mem_ack) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Fires in the MEM_TIMEOUT_CYCLES-th consecutive MEM cycle without an ack.
  assign to_expire = (state == S_MEM) && !mem_ack &&
                     (to_cnt == TO_W'(MEM_TIMEOUT_CYCLES - 1));
`else
  // No watchdog: MEM waits for mem_ack indefinitely.
  assign to_expire = 1'b0;
`endif

  // State register; asynchronous reset aborts any operation immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Instruction latch, ALU result capture in EXEC and load data capture on ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction <= '0;
      alu_q       <= '0;
      rdata_q     <= '0;
    end else begin
      if (state == S_IDLE && instr_valid) begin
        instruction <= instr_in;
      end
      if (state == S_EXEC) begin
        alu_q <= ALUResult;
      end
      if (state == S_MEM && mem_ack && dec_is_load) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // Next-state and output decode; every output is a function of the state
  // so RegWrite/mem_req drop in the same instant the reset forces IDLE.
  always_comb begin
    state_nx     = state;
    instr_ready  = 1'b0;
    ALUScr       = 1'b0;
    RegDst       = 1'b0;
    ALUControl   = ALU_ADD;
    RegWrite     = 1'b0;
    write_data   = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    branch_taken = 1'b0;
    illegal      = 1'b0;

    if (state != S_IDLE) begin
      ALUScr     = dec_alu_src;
      RegDst     = dec_reg_dst;
      ALUControl = dec_alu_ctrl;
    end

    case (state)
      S_IDLE: begin
        instr_ready = rst;
        if (instr_valid) begin
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        illegal  = dec_illegal;
        state_nx = dec_illegal ? S_IDLE : S_EXEC;
      end
      S_EXEC: begin
        if (dec_is_branch) begin
          branch_taken = Zero;
          state_nx     = S_IDLE;
        end else if (dec_is_load || dec_is_store) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = dec_is_store;
        mem_addr  = alu_q;
        mem_wdata = rt_data;
        if (mem_ack) begin
          state_nx = dec_is_load ? S_WB : S_IDLE;
        end else if (to_expire) begin
          illegal  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        write_data = dec_is_load ? rdata_q : alu_q;
        state_nx   = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Self-checking bench for mips_control_fsm: hand-written vector table,
// reset/abort sequences, and randomized instructions checked against a
// transaction-level reference model plus a write-back scoreboard.
`timescale 1ns/1ps
module tb_mips_control_fsm;
  import mips_pkg::*;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_in = '0;
  logic [DATA_W-1:0] instruction;
  logic              ALUScr, RegWrite, RegDst;
  logic [3:0]        ALUControl;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] ALUResult = '0;
  logic              Zero = 1'b0;
  logic [DATA_W-1:0] rt_data = '0;
  logic              mem_req, mem_we;
  logic [DATA_W-1:0] mem_addr, mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic              branch_taken, illegal;
  logic [2:0]        state_dbg;

  mips_control_fsm #(.DATA_W(DATA_W), .MEM_TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_in(instr_in),
    .instruction(instruction), .ALUScr(ALUScr), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUControl(ALUControl), .write_data(write_data), .ALUResult(ALUResult), .Zero(Zero),
    .rt_data(rt_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .branch_taken(branch_taken), .illegal(illegal), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];

  typedef struct {
    int          busy;
    int          n_branch;
    int          n_regwr;
    logic [31:0] wdata;
    int          wr_idx;
    int          n_illegal;
    int          n_memreq;
    logic [31:0] maddr;
    logic        mwe;
    logic [31:0] mwdata;
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic        reg_dst;
    logic [31:0] instr_out;
    bit          chk_dec;
    bit          chk_dst;
    bit          timed_out;
  } res_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] rt;
    logic [31:0] rdata;
    int          delay;
    res_t        exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic res_t blank();
    res_t r;
    r.busy = 0; r.n_branch = 0; r.n_regwr = 0; r.wdata = '0; r.wr_idx = 0;
    r.n_illegal = 0; r.n_memreq = 0; r.maddr = '0; r.mwe = 1'b0; r.mwdata = '0;
    r.alu_ctrl = 4'b0010; r.alu_src = 1'b0; r.reg_dst = 1'b0; r.instr_out = '0;
    r.chk_dec = 1'b0; r.chk_dst = 1'b0; r.timed_out = 1'b0;
    return r;
  endfunction

  // Hand-written vector: stimulus plus the expected transaction outcome.
  function automatic vec_t mkv(input logic [31:0] ins, input logic [31:0] alu, input logic z,
                               input logic [31:0] rt, input logic [31:0] rd, input int d,
                               input int busy, input int nbr, input int nwr, input logic [31:0] wd,
                               input int nill, input int nmem, input logic we,
                               input logic [3:0] ctl, input logic src, input logic dst,
                               input bit cdec, input bit cdst);
    vec_t v;
    v.instr = ins; v.alu = alu; v.zero = z; v.rt = rt; v.rdata = rd; v.delay = d;
    v.exp = blank();
    v.exp.busy = busy; v.exp.n_branch = nbr; v.exp.n_regwr = nwr; v.exp.wdata = wd;
    v.exp.n_illegal = nill; v.exp.n_memreq = nmem; v.exp.maddr = alu; v.exp.mwe = we;
    v.exp.mwdata = rt; v.exp.alu_ctrl = ctl; v.exp.alu_src = src; v.exp.reg_dst = dst;
    v.exp.instr_out = ins; v.exp.chk_dec = cdec; v.exp.chk_dst = cdst;
    return v;
  endfunction

  // Reference model: outcome of one instruction from the ISA rules and the
  // cycle budget (DECODE + EXEC + MEM wait + WB), given ack after d waits.
  function automatic res_t model(input logic [31:0] ins, input logic [31:0] alu, input logic z,
                                 input logic [31:0] rt, input logic [31:0] rd, input int d);
    res_t e;
    bit legal;
    logic [5:0] op;
    logic [5:0] fn;
    e = blank();
    legal = 1'b1;
    op = ins[31:26];
    fn = ins[5:0];
    e.instr_out = ins; e.maddr = alu; e.mwdata = rt; e.chk_dec = 1'b1; e.chk_dst = 1'b1;
    if (op == 6'h00) begin
      e.reg_dst = 1'b1; e.busy = 3; e.n_regwr = 1; e.wdata = alu;
      if (fn == 6'h20 || fn == 6'h00) e.alu_ctrl = 4'b0010;
      else if (fn == 6'h22) e.alu_ctrl = 4'b0110;
      else if (fn == 6'h24) e.alu_ctrl = 4'b0000;
      else if (fn == 6'h25) e.alu_ctrl = 4'b0001;
      else if (fn == 6'h2A) e.alu_ctrl = 4'b0111;
      else legal = 1'b0;
    end else if (op == 6'h08) begin
      e.alu_src = 1'b1; e.busy = 3; e.n_regwr = 1; e.wdata = alu;
    end else if (op == 6'h23) begin
      e.alu_src = 1'b1; e.n_memreq = d + 1; e.busy = 2 + (d + 1) + 1;
      e.n_regwr = 1; e.wdata = rd;
    end else if (op == 6'h2B) begin
      e.alu_src = 1'b1; e.n_memreq = d + 1; e.busy = 2 + (d + 1); e.mwe = 1'b1;
    end else if (op == 6'h04) begin
      e.alu_ctrl = 4'b0110; e.busy = 2; e.n_branch = z ? 1 : 0; e.chk_dst = 1'b0;
    end else begin
      legal = 1'b0;
    end
    if (!legal) begin
      e = blank();
      e.instr_out = ins; e.busy = 1; e.n_illegal = 1;
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  // Offers one instruction, then watches every cycle until instr_ready returns,
  // answering the memory request with mem_ack after d wait cycles.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] alu, input logic z,
                           input logic [31:0] rt, input logic [31:0] rd, input int d,
                           input bit noise, output res_t o);
    int guard;
    bit done;
    o = blank();
    guard = 0;
    while (!instr_ready && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    if (!instr_ready) begin
      o.timed_out = 1'b1;
    end else begin
      instr_valid = 1'b1; instr_in = ins; ALUResult = alu; Zero = z; rt_data = rt; mem_rdata = rd;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      instr_in = $urandom();
      done = 1'b0;
      for (int c = 1; c <= 64 && !done; c++) begin
        if (mem_req) mem_ack = (o.n_memreq == d);
        else mem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        if (instr_ready) begin
          o.busy = c - 1;
          done = 1'b1;
        end else begin
          if (c == 1) begin
            o.alu_ctrl = ALUControl; o.alu_src = ALUScr; o.reg_dst = RegDst; o.instr_out = instruction;
          end
          if (branch_taken) o.n_branch++;
          if (illegal) o.n_illegal++;
          if (mem_req) begin
            o.n_memreq++; o.maddr = mem_addr; o.mwe = mem_we; o.mwdata = mem_wdata;
          end
          if (RegWrite) begin
            o.n_regwr++; o.wr_idx = c; o.wdata = write_data;
            if (exp_q.size() > 0) begin
              chk("sb_write_data", write_data, exp_q.pop_front());
            end else begin
              n_cmp++; n_err++;
              $display("FAIL sb_unexpected_write: got write_data %h with no write expected", write_data);
            end
          end
          @(negedge clk);
        end
      end
      if (!done) o.timed_out = 1'b1;
      mem_ack = 1'b0;
    end
  endtask

  task automatic compare(input string tag, input res_t o, input res_t e);
    chk({tag, " timed_out"}, 32'(o.timed_out), 32'(e.timed_out));
    chk({tag, " busy"}, o.busy, e.busy);
    chk({tag, " branch"}, o.n_branch, e.n_branch);
    chk({tag, " regwrite"}, o.n_regwr, e.n_regwr);
    chk({tag, " illegal"}, o.n_illegal, e.n_illegal);
    chk({tag, " mem_req_cycles"}, o.n_memreq, e.n_memreq);
    chk({tag, " instruction"}, o.instr_out, e.instr_out);
    if (e.n_regwr > 0) chk({tag, " wb_cycle"}, o.wr_idx, e.busy);
    if (e.n_memreq > 0) begin
      chk({tag, " mem_addr"}, o.maddr, e.maddr);
      chk({tag, " mem_we"}, 32'(o.mwe), 32'(e.mwe));
      chk({tag, " mem_wdata"}, o.mwdata, e.mwdata);
    end
    if (e.chk_dec) begin
      chk({tag, " ALUControl"}, 32'(o.alu_ctrl), 32'(e.alu_ctrl));
      chk({tag, " ALUScr"}, 32'(o.alu_src), 32'(e.alu_src));
    end
    if (e.chk_dst) chk({tag, " RegDst"}, 32'(o.reg_dst), 32'(e.reg_dst));
  endtask

  task automatic do_vec(input string tag, input vec_t v, input bit noise);
    res_t o;
    if (v.exp.n_regwr > 0) exp_q.push_back(v.exp.wdata);
    run_instr(v.instr, v.alu, v.zero, v.rt, v.rdata, v.delay, noise, o);
    compare(tag, o, v.exp);
  endtask

  logic [5:0] fn_pool[7] = '{6'h20, 6'h00, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h03};

  // Global time bound so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t tbl[$];
    vec_t v;
    logic [31:0] ins;
    int g;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst mem_req", 32'(mem_req), 0);
    chk("rst RegWrite", 32'(RegWrite), 0);
    chk("rst illegal", 32'(illegal), 0);
    chk("rst branch_taken", 32'(branch_taken), 0);
    chk("rst ALUControl", 32'(ALUControl), 32'h2);
    chk("rst instruction", instruction, 0);
    chk("rst write_data", write_data, 0);
    chk("rst state", 32'(state_dbg), 32'(S_IDLE));
    rst = 1'b1;
    @(negedge clk); #1;
    chk("post-rst instr_ready", 32'(instr_ready), 1);

    //                ins            alu           z  rt            rdata         d  busy br wr wdata        il mem we ctl      src dst cdec cdst
    tbl.push_back(mkv(32'h8C010002, 32'h2,        0, 32'h11,       32'h2,        3, 7,   0, 1, 32'h2,        0, 4,  0, 4'b0010, 1, 0, 1, 1));
    tbl.push_back(mkv(32'h00220800, 32'h6,        0, 32'h0,        32'h0,        0, 3,   0, 1, 32'h6,        0, 0,  0, 4'b0010, 0, 1, 1, 1));
    tbl.push_back(mkv(32'h10220003, 32'h0,        1, 32'h0,        32'h0,        0, 2,   1, 0, 32'h0,        0, 0,  0, 4'b0110, 0, 0, 1, 0));
    tbl.push_back(mkv(32'h10220003, 32'h5,        0, 32'h0,        32'h0,        0, 2,   0, 0, 32'h0,        0, 0,  0, 4'b0110, 0, 0, 1, 0));
    tbl.push_back(mkv(32'hAC030008, 32'h8,        0, 32'hDEADBEEF, 32'h0,        2, 5,   0, 0, 32'h0,        0, 3,  1, 4'b0010, 1, 0, 1, 1));
    tbl.push_back(mkv(32'hFC000000, 32'h0,        0, 32'h0,        32'h0,        0, 1,   0, 0, 32'h0,        1, 0,  0, 4'b0010, 0, 0, 0, 0));
    tbl.push_back(mkv(32'h00430822, 32'hFFFFFFFE, 0, 32'h0,        32'h0,        0, 3,   0, 1, 32'hFFFFFFFE, 0, 0,  0, 4'b0110, 0, 1, 1, 1));
    tbl.push_back(mkv(32'h00430824, 32'h000000F0, 0, 32'h0,        32'h0,        0, 3,   0, 1, 32'h000000F0, 0, 0,  0, 4'b0000, 0, 1, 1, 1));
    tbl.push_back(mkv(32'h00430825, 32'h000000FF, 0, 32'h0,        32'h0,        0, 3,   0, 1, 32'h000000FF, 0, 0,  0, 4'b0001, 0, 1, 1, 1));
    tbl.push_back(mkv(32'h0043082A, 32'h1,        0, 32'h0,        32'h0,        0, 3,   0, 1, 32'h1,        0, 0,  0, 4'b0111, 0, 1, 1, 1));
    tbl.push_back(mkv(32'h20010005, 32'h5,        0, 32'h0,        32'h0,        0, 3,   0, 1, 32'h5,        0, 0,  0, 4'b0010, 1, 0, 1, 1));
    tbl.push_back(mkv(32'h00430803, 32'h0,        0, 32'h0,        32'h0,        0, 1,   0, 0, 32'h0,        1, 0,  0, 4'b0010, 0, 0, 0, 0));
    tbl.push_back(mkv(32'h8C220010, 32'h10,       0, 32'h5,        32'hCAFEF00D, 0, 4,   0, 1, 32'hCAFEF00D, 0, 1,  0, 4'b0010, 1, 0, 1, 1));
    tbl.push_back(mkv(32'hAC450004, 32'h4,        0, 32'h12345678, 32'h0,        0, 3,   0, 0, 32'h0,        0, 1,  1, 4'b0010, 1, 0, 1, 1));
    tbl.push_back(mkv(32'h00851020, 32'h77,       0, 32'h0,        32'h0,        0, 3,   0, 1, 32'h77,       0, 0,  0, 4'b0010, 0, 1, 1, 1));

    foreach (tbl[i]) begin
      do_vec($sformatf("vec%0d", i), tbl[i], 1'b0);
    end

    // Reset dropped while a load sits in MEM: outputs must fall at once.
    g = 0;
    while (!instr_ready && g < 20) begin @(negedge clk); #1; g++; end
    instr_valid = 1'b1; instr_in = 32'h8C010002; ALUResult = 32'h40;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    for (int k = 0; k < 10 && !mem_req; k++) begin
      @(negedge clk); #1;
    end
    chk("midrst reached MEM", 32'(mem_req), 1);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst mem_req", 32'(mem_req), 0);
    chk("midrst RegWrite", 32'(RegWrite), 0);
    chk("midrst instruction", instruction, 0);
    chk("midrst ALUControl", 32'(ALUControl), 32'h2);
    @(posedge clk); #1;
    chk("midrst held mem_req", 32'(mem_req), 0);
    chk("midrst held RegWrite", 32'(RegWrite), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst recover instr_ready", 32'(instr_ready), 1);
    v.instr = 32'h00220800; v.alu = 32'h9; v.zero = 1'b0; v.rt = '0; v.rdata = '0; v.delay = 0;
    v.exp = model(v.instr, v.alu, v.zero, v.rt, v.rdata, v.delay);
    do_vec("post-midrst add", v, 1'b0);

`ifdef MIPS_MEM_TIMEOUT_EN
    // Load with no ack at all: watchdog aborts after TIMEOUT MEM cycles.
    v = mkv(32'h8C010002, 32'h2, 0, 32'h0, 32'h0, 1000, 2 + TIMEOUT, 0, 0, 32'h0,
            1, TIMEOUT, 0, 4'b0010, 1, 0, 1, 1);
    do_vec("mem timeout", v, 1'b0);
`endif

    // Randomized instructions against the reference model.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 7))
        0, 1: ins = {6'h00, 20'($urandom()), fn_pool[$urandom_range(0, 6)]};
        2:    ins = {6'h23, 26'($urandom())};
        3:    ins = {6'h2B, 26'($urandom())};
        4:    ins = {6'h08, 26'($urandom())};
        5:    ins = {6'h04, 26'($urandom())};
        6:    ins = 32'($urandom());
        default: ins = {6'h00, 20'($urandom()), 6'($urandom())};
      endcase
      v.instr = ins;
      v.alu = 32'($urandom());
      v.zero = 1'($urandom_range(0, 1));
      v.rt = 32'($urandom());
      v.rdata = 32'($urandom());
      v.delay = $urandom_range(0, 5);
      v.exp = model(v.instr, v.alu, v.zero, v.rt, v.rdata, v.delay);
      do_vec($sformatf("rnd%0d", n), v, 1'b1);
    end

    chk("sb_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
